// File: rtl/alu_addsub_result_stage_pkg.sv
// Shared types and constants for the adder/subtractor result stage.
// The beat struct is the finished form of one adder result: the value that
// leaves the stage plus the four condition flags that travel with it.
package alu_pkg;

    // Native datapath width of the adder that feeds this stage.
    localparam int DATA_W = 32;

    // Occupancy of the two-entry output buffer (main + skid).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Finished beat: final result and its flags, stored as one word.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              n;
        logic              z;
        logic              v;
        logic              lt;
    } beat_t;

    // Signed extremes used when an overflowed result is clamped.
    localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    // Clamp value for an overflowed sum. An overflowed sum has the wrong
    // sign bit: MSB=0 means the true result was negative, MSB=1 positive.
    function automatic logic [DATA_W-1:0] sat_value(input logic sum_msb);
        logic [DATA_W-1:0] value;
        if (sum_msb) begin
            value = SAT_POS;
        end else begin
            value = SAT_NEG;
        end
        return value;
    endfunction

endpackage

// File: rtl/alu_addsub_result_stage_if.sv
// Valid/ready bus around the result stage: the upstream beat (adder sum,
// overflow, operation) and the downstream result beat with its flags.
// "slave" is the view of the stage itself, "master" the view of the
// surrounding logic that feeds it and consumes its output.
interface alu_addsub_result_stage_if #(
    parameter int WIDTH = 32
);

    // Upstream side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic             in_ovf;
    logic             in_sub;

    // Downstream side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_n;
    logic             out_z;
    logic             out_v;
    logic             out_lt;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_sum,
        input  in_ovf,
        input  in_sub,
        output out_valid,
        input  out_ready,
        output out_result,
        output out_n,
        output out_z,
        output out_v,
        output out_lt
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_sum,
        output in_ovf,
        output in_sub,
        input  out_valid,
        output out_ready,
        input  out_result,
        input  out_n,
        input  out_z,
        input  out_v,
        input  out_lt
    );

endinterface

// File: rtl/alu_addsub_result_stage_flag_gen.sv
// Turns a raw adder sum into a finished beat: optional saturation of the
// result, N/Z taken from the final result, V/LT taken from the raw sum and
// overflow. Purely combinational; sits in front of the storage registers so
// both buffer entries hold ready-to-send beats.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_ovf,
    input  logic             in_sub,
    output beat_t            beat
);

    logic [DATA_W-1:0] result_s;
    logic              lt_s;

    // Final result: clamp to the signed extreme on overflow when enabled.
    always_comb begin
        result_s = in_sum;
        if (SATURATE && in_ovf) begin
            result_s = sat_value(in_sum[WIDTH-1]);
        end else begin
            result_s = in_sum;
        end
    end

    // Signed less-than is the sign of the true difference, only for subtracts.
    always_comb begin
        lt_s = 1'b0;
        if (in_sub) begin
            lt_s = in_sum[WIDTH-1] ^ in_ovf;
        end else begin
            lt_s = 1'b0;
        end
    end

    assign beat.result = result_s;
    assign beat.n      = result_s[DATA_W-1];
    assign beat.z      = (result_s == {DATA_W{1'b0}});
    assign beat.v      = in_ovf;
    assign beat.lt     = lt_s;

endmodule

// File: rtl/alu_addsub_result_stage.sv
// Registered output stage behind the 32-bit adder/subtractor.
// Finished beats are held in a two-entry buffer: "main" drives the outputs,
// "skid" catches the one beat that can arrive in the cycle in_ready is still
// high while the consumer stalls. This keeps in_ready a pure flop while
// sustaining one beat per cycle. A saturating counter tallies accepted
// beats that overflowed.
module alu_addsub_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter bit SATURATE = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_addsub_result_stage_if.slave bus,
    input  logic                    ovf_clr,
    output logic [CNT_W-1:0]        ovf_count
);

    state_t           state_r;
    beat_t            main_r;
    beat_t            skid_r;
    beat_t            beat_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;
    logic             drain_s;
    logic             cnt_full_s;

    // Finalise the incoming beat before it is stored anywhere.
    alu_flag_gen #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_flag_gen (
        .in_sum (bus.in_sum),
        .in_ovf (bus.in_ovf),
        .in_sub (bus.in_sub),
        .beat   (beat_s)
    );

    assign accept_s   = bus.in_valid & in_ready_r;
    assign drain_s    = out_valid_r & bus.out_ready;
    assign cnt_full_s = &cnt_r;

    // Buffer occupancy FSM; out_valid and in_ready are updated alongside the
    // state so both leave the block straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            main_r      <= '0;
            skid_r      <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        main_r      <= beat_s;
                        state_r     <= ONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ONE: begin
                    if (accept_s && drain_s) begin
                        // Pass-through: the new beat replaces the one leaving.
                        main_r     <= beat_s;
                        in_ready_r <= 1'b1;
                    end else if (accept_s) begin
                        // Consumer stalled: park the new beat behind main.
                        skid_r     <= beat_s;
                        state_r    <= TWO;
                        in_ready_r <= 1'b0;
                    end else if (drain_s) begin
                        state_r     <= EMPTY;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain_s) begin
                        main_r     <= skid_r;
                        state_r    <= ONE;
                        in_ready_r <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    // Overflow event counter: clear wins, then count up to all-ones and stick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (ovf_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && bus.in_ovf && !cnt_full_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = main_r.result;
    assign bus.out_n      = main_r.n;
    assign bus.out_z      = main_r.z;
    assign bus.out_v      = main_r.v;
    assign bus.out_lt     = main_r.lt;
    assign ovf_count      = cnt_r;

endmodule

// File: tb/tb_alu_addsub_result_stage.sv
// Bench for alu_addsub_result_stage. Two instances share one stimulus
// stream: dut0 wraps (SATURATE=0, 4-bit counter), dut1 saturates (16-bit
// counter). Stimulus is given as signed operands X, Y and an operation; the
// bench derives the adder sum/overflow and the expected results from true
// signed arithmetic, queues expected beats in FIFO order and compares every
// cycle on the falling edge.
module tb_alu_addsub_result_stage;

    typedef struct packed {
        logic [31:0] result;
        logic        n;
        logic        z;
        logic        v;
        logic        lt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ovf_clr;
    logic [3:0]  cnt0;
    logic [15:0] cnt1;

    logic [31:0] cur_x;
    logic [31:0] cur_y;
    logic        cur_sub;

    int          checks;
    int          errors;
    int          drains0;
    bit          ready_armed;

    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned mcnt0;
    int unsigned mcnt1;

    alu_addsub_result_stage_if #(.WIDTH(32)) bus0 ();
    alu_addsub_result_stage_if #(.WIDTH(32)) bus1 ();

    alu_addsub_result_stage #(
        .WIDTH    (32),
        .SATURATE (1'b0),
        .CNT_W    (4)
    ) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus0.slave),
        .ovf_clr   (ovf_clr),
        .ovf_count (cnt0)
    );

    alu_addsub_result_stage #(
        .WIDTH    (32),
        .SATURATE (1'b1),
        .CNT_W    (16)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1.slave),
        .ovf_clr   (ovf_clr),
        .ovf_count (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in_ready may only be high from the first rising edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_armed <= 1'b0;
        else        ready_armed <= 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beat from the true signed result of X op Y.
    function automatic exp_t model_beat(input logic [31:0] x, input logic [31:0] y,
                                        input logic sub, input bit sat);
        longint tx;
        longint ty;
        longint t;
        logic   ovf;
        exp_t   e;
        tx  = longint'($signed(x));
        ty  = longint'($signed(y));
        t   = sub ? (tx - ty) : (tx + ty);
        ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        if (sat && ovf) e.result = (t < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else            e.result = t[31:0];
        e.n  = e.result[31];
        e.z  = (e.result == 32'h0);
        e.v  = ovf;
        e.lt = sub && (tx < ty);
        return e;
    endfunction

    // Present one upstream beat to both instances (adder behaviour included).
    task automatic set_beat(input logic v, input logic [31:0] x, input logic [31:0] y, input logic sub);
        longint tx;
        longint ty;
        longint t;
        logic   ovf;
        tx  = longint'($signed(x));
        ty  = longint'($signed(y));
        t   = sub ? (tx - ty) : (tx + ty);
        ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        cur_x = x;
        cur_y = y;
        cur_sub = sub;
        bus0.in_valid = v; bus0.in_sum = t[31:0]; bus0.in_ovf = ovf; bus0.in_sub = sub;
        bus1.in_valid = v; bus1.in_sum = t[31:0]; bus1.in_ovf = ovf; bus1.in_sub = sub;
    endtask

    task automatic drive_ready(input logic r);
        bus0.out_ready = r;
        bus1.out_ready = r;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Hold a valid beat until it is taken; returns the number of stalled cycles.
    task automatic offer(input logic [31:0] x, input logic [31:0] y, input logic sub, output int waits);
        set_beat(1'b1, x, y, sub);
        waits = 0;
        forever begin
            @(negedge clk);
            if (bus0.in_ready) break;
            waits++;
            if (waits > 50) begin
                check("offer accepted", 64'(bus0.in_ready), 64'd1);
                break;
            end
        end
        sync();
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            3:       return 32'($urandom_range(0, 3));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic side_check(input string tag, input int occ, input exp_t front,
                              input logic ov, input logic ir, input exp_t got,
                              input int unsigned cnt, input int unsigned mcnt);
        check({tag, " out_valid"}, 64'(ov), 64'(occ != 0));
        check({tag, " in_ready"}, 64'(ir), 64'(ready_armed && (occ < 2)));
        if (occ != 0) check({tag, " beat"}, 64'(got), 64'(front));
        check({tag, " ovf_count"}, 64'(cnt), 64'(mcnt));
    endtask

    // Compare process: check outputs against the FIFO model, then advance it
    // with the handshakes that will take place at the coming rising edge.
    initial begin
        exp_t e0;
        exp_t e1;
        bit   acc0;
        bit   acc1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                mcnt0 = 0;
                mcnt1 = 0;
            end else begin
                side_check("dut0", q0.size(), (q0.size() != 0) ? q0[0] : exp_t'(0),
                           bus0.out_valid, bus0.in_ready,
                           {bus0.out_result, bus0.out_n, bus0.out_z, bus0.out_v, bus0.out_lt},
                           32'(cnt0), mcnt0);
                side_check("dut1", q1.size(), (q1.size() != 0) ? q1[0] : exp_t'(0),
                           bus1.out_valid, bus1.in_ready,
                           {bus1.out_result, bus1.out_n, bus1.out_z, bus1.out_v, bus1.out_lt},
                           32'(cnt1), mcnt1);
                if (bus0.out_valid && bus0.out_ready) drains0++;
                e0   = model_beat(cur_x, cur_y, cur_sub, 1'b0);
                e1   = model_beat(cur_x, cur_y, cur_sub, 1'b1);
                acc0 = bus0.in_valid && ready_armed && (q0.size() < 2);
                acc1 = bus1.in_valid && ready_armed && (q1.size() < 2);
                if ((q0.size() != 0) && bus0.out_ready) void'(q0.pop_front());
                if ((q1.size() != 0) && bus1.out_ready) void'(q1.pop_front());
                if (acc0) q0.push_back(e0);
                if (acc1) q1.push_back(e1);
                if (ovf_clr)                          mcnt0 = 0;
                else if (acc0 && e0.v && mcnt0 < 15)  mcnt0++;
                if (ovf_clr)                          mcnt1 = 0;
                else if (acc1 && e1.v && mcnt1 < 65535) mcnt1++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   w;
        int   total;
        int   d_start;
        bit   acc;
        checks  = 0;
        errors  = 0;
        drains0 = 0;
        rst_n   = 1'b0;
        ovf_clr = 1'b0;
        set_beat(1'b0, 32'h0, 32'h0, 1'b0);
        drive_ready(1'b0);

        // Reset release: in_ready low until the first rising edge after it.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("release in_ready low", 64'({bus0.in_ready, bus1.in_ready}), 64'd0);
        sync();
        check("release in_ready high", 64'({bus0.in_ready, bus1.in_ready}), 64'b11);
        drive_ready(1'b1);

        // Zero add.
        offer(32'h0, 32'h0, 1'b0, w);
        set_beat(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("zero add", 64'({bus0.out_valid, bus0.out_result, bus0.out_n, bus0.out_z, bus0.out_v, bus0.out_lt}),
              64'({1'b1, 32'h0, 4'b0100}));
        sync();

        // 0x80000000 - 1 overflows.
        offer(32'h8000_0000, 32'd1, 1'b1, w);
        set_beat(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("sub ovf wrap", 64'({bus0.out_result, bus0.out_n, bus0.out_z, bus0.out_v, bus0.out_lt}),
              64'({32'h7FFF_FFFF, 4'b0011}));
        check("sub ovf sat", 64'({bus1.out_result, bus1.out_n, bus1.out_z, bus1.out_v, bus1.out_lt}),
              64'({32'h8000_0000, 4'b1011}));
        check("sub ovf count", 64'(cnt0), 64'd1);
        sync();

        // Backpressure: A to main, B to skid, C held upstream.
        drive_ready(1'b0);
        offer(32'd1, 32'd2, 1'b0, w);
        offer(32'd10, 32'd3, 1'b1, w);
        set_beat(1'b1, 32'd100, 32'd100, 1'b0);
        @(negedge clk);
        check("bp in_ready", 64'(bus0.in_ready), 64'd0);
        check("bp hold A", 64'(bus0.out_result), 64'd3);
        sync();
        drive_ready(1'b1);
        @(negedge clk);
        check("bp out A", 64'(bus0.out_result), 64'd3);
        @(negedge clk);
        check("bp out B", 64'(bus0.out_result), 64'd7);
        sync();
        set_beat(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("bp out C", 64'({bus0.out_valid, bus0.out_result}), 64'({1'b1, 32'd200}));
        sync();

        // Streaming: eight back-to-back beats, no stalls.
        total   = 0;
        d_start = drains0;
        for (int i = 0; i < 8; i++) begin
            offer(32'(i * 3 + 1), 32'(i), 1'(i), w);
            total += w;
        end
        set_beat(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        sync();
        check("stream stalls", 64'(total), 64'd0);
        check("stream outputs", 64'(drains0 - d_start), 64'd8);

        // Asynchronous reset with a beat held in main.
        drive_ready(1'b0);
        offer(32'd5, 32'd6, 1'b0, w);
        set_beat(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst dut0", 64'({bus0.out_valid, bus0.in_ready, cnt0, bus0.out_result,
                               bus0.out_n, bus0.out_z, bus0.out_v, bus0.out_lt}), 64'd0);
        check("rst dut1", 64'({bus1.out_valid, bus1.in_ready, bus1.out_result,
                               bus1.out_n, bus1.out_z, bus1.out_v, bus1.out_lt}), 64'd0);
        check("rst cnt1", 64'(cnt1), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst release low", 64'(bus0.in_ready), 64'd0);
        sync();
        check("rst release high", 64'(bus0.in_ready), 64'd1);
        drive_ready(1'b1);

        // Counter saturation and clear priority.
        for (int i = 0; i < 20; i++) offer(32'h7FFF_FFFF, 32'd1, 1'b0, w);
        set_beat(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("count sat4", 64'(cnt0), 64'd15);
        check("count 16", 64'(cnt1), 64'd20);
        sync();
        ovf_clr = 1'b1;
        offer(32'h7FFF_FFFF, 32'd1, 1'b0, w);
        ovf_clr = 1'b0;
        set_beat(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("clr wins", 64'({cnt0, cnt1}), 64'd0);
        sync();

        // Randomized traffic with random backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = bus0.in_valid && bus0.in_ready;
            sync();
            if (acc || !bus0.in_valid) begin
                if ($urandom_range(0, 3) != 0) set_beat(1'b1, rnd32(), rnd32(), 1'($urandom_range(0, 1)));
                else                           set_beat(1'b0, 32'h0, 32'h0, 1'b0);
            end
            drive_ready($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 31) == 0);
        end
        sync();
        set_beat(1'b0, 32'h0, 32'h0, 1'b0);
        drive_ready(1'b1);
        ovf_clr = 1'b0;
        repeat (4) sync();
        check("final empty", 64'({bus0.out_valid, bus1.out_valid}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
